// File: rtl/clyde_tweakey_sched.sv
// Clyde tweakey schedule sequencer: drives the public tweak contribution
// (delta) and round constant (W) to the Clyde datapath, one phase per adv.
// Optional feature: define CLYDE_SCHED_ABORT_EN to add an abort input that
// cancels a running schedule without a done pulse.
module clyde_tweakey_sched #(
  parameter int Nbits  = 128,
  parameter int NSTEPS = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [Nbits-1:0] tweak,
  input  logic             adv,
`ifdef CLYDE_SCHED_ABORT_EN
  input  logic             abort,
`endif
  output logic [Nbits-1:0] delta,
  output logic [3:0]       W,
  output logic             ctrl_TK_addition,
  output logic             ctrl_W_addition,
  output logic [2:0]       step_idx,
  output logic             busy,
  output logic             done
);

  localparam int         H    = Nbits / 2;
  localparam logic [2:0] LAST = 3'(NSTEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_TK,
    S_ROUND_A,
    S_ROUND_B,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [H-1:0]   r_t0;
  logic [H-1:0]   r_t1;
  logic [3:0]     r_lfsr;
  logic [2:0]     r_step;
  logic           w_abort;
  logic [3:0]     w_lfsr_step;

`ifdef CLYDE_SCHED_ABORT_EN
  assign w_abort = abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_lfsr_step = {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; abort takes priority over adv
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_next = S_INIT_TK;
      S_INIT_TK: if (adv)   w_next = S_ROUND_A;
      S_ROUND_A: if (adv)   w_next = S_ROUND_B;
      S_ROUND_B: if (adv)   w_next = (r_step == LAST) ? S_DONE : S_ROUND_A;
      S_DONE:               w_next = S_IDLE;
      default:              w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  // Tweak halves, LFSR and step counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t0   <= '0;
      r_t1   <= '0;
      r_lfsr <= '0;
      r_step <= '0;
    end else if (w_abort) begin
      r_t0   <= '0;
      r_t1   <= '0;
      r_lfsr <= '0;
      r_step <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_t0   <= tweak[H-1:0];
            r_t1   <= tweak[Nbits-1:H];
            r_lfsr <= 4'b1000;
            r_step <= '0;
          end
        end
        S_ROUND_A: begin
          if (adv) begin
            r_t0   <= r_t0 ^ r_t1;
            r_t1   <= r_t0;
            r_lfsr <= w_lfsr_step;
          end
        end
        S_ROUND_B: begin
          if (adv) begin
            r_lfsr <= w_lfsr_step;
            if (r_step != LAST) r_step <= r_step + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore output decode from the state and data registers
  always_comb begin
    busy             = (r_state != S_IDLE);
    done             = (r_state == S_DONE);
    ctrl_TK_addition = (r_state == S_INIT_TK) || (r_state == S_ROUND_B);
    ctrl_W_addition  = (r_state == S_ROUND_A) || (r_state == S_ROUND_B);
    delta            = ctrl_TK_addition ? {r_t1, r_t0} : '0;
    W                = ctrl_W_addition ? r_lfsr : '0;
    step_idx         = r_step;
  end

endmodule
